// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle shared by the requesters, the round-robin arbiter and uart_tx.
// The arbiter takes the slave view; the requester/transmitter side takes the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx byte transmitter between NUM_REQ message sources.
// A grant lasts a whole message (last byte or MAX_BYTES), optionally followed by an idle gap.
module uart_tx_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  MAX_BYTES  = 64,
  parameter int  GAP_CYCLES = 0,
  localparam int GID_W      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic [GID_W-1:0] grant_id,
  output logic             msg_done
);

  localparam int               GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]       MAX_B    = 8'(MAX_BYTES);
  localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             busy_q, busy_d;
  logic             msg_done_q, msg_done_d;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               tx_valid_c;
  logic [7:0]         tx_data_c;
  logic               last_sel;
  logic               xfer;
  logic [GID_W:0]     cand;
  logic [GID_W-1:0]   winner;
  logic               winner_ok;
  logic [GID_W-1:0]   next_ptr;

  // Only the granted requester is routed; tx_ready feeds req_ready but never tx_valid.
  always_comb begin
    req_ready_c = '0;
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    last_sel    = 1'b0;
    if (state_q == GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == GID_W'(i)) begin
          tx_valid_c     = bus.req_valid[i];
          tx_data_c      = bus.req_data[8*i +: 8];
          last_sel       = bus.req_last[i];
          req_ready_c[i] = bus.tx_ready;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign xfer          = tx_valid_c && bus.tx_ready;

  // Walk offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    cand      = '0;
    winner    = '0;
    winner_ok = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (GID_W+1)'(k);
      if (cand >= (GID_W+1)'(NUM_REQ)) begin
        cand = cand - (GID_W+1)'(NUM_REQ);
      end
      if (bus.req_valid[cand[GID_W-1:0]]) begin
        winner    = cand[GID_W-1:0];
        winner_ok = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + GID_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    msg_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner_ok) begin
          grant_id_d = winner;
          byte_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          // A last byte that also hits the byte limit is still a single release.
          if (last_sel || (byte_cnt_q + 8'd1 == MAX_B)) begin
            rr_ptr_d   = next_ptr;
            msg_done_d = 1'b1;
            gap_cnt_d  = '0;
            state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign msg_done = msg_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed message scenarios plus randomized traffic,
// all compared every cycle against a message-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;
  localparam int GC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       msg_done;
  logic [1:0] grant_id;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BYTES (MB),
    .GAP_CYCLES(GC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .grant_id(grant_id),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Each source queue entry is {last, byte}.
  logic [8:0]    src_q      [NR][$];
  logic [7:0]    exp_stream [NR][$];
  logic [NR-1:0] hold    = '0;
  logic [NR-1:0] hs_mask = '0;
  int            tx_mode = 0;
  int            bp_idx  = 0;

  // Message-level model: who owns the link, bytes sent this grant, gap cycles left.
  int m_owner = -1;
  int m_sent  = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  int m_gid   = 0;
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;

  int         obs_gid  [$];
  int         obs_cyc  [$];
  logic [7:0] obs_data [$];
  int         done_cyc [$];
  bit         other_rdy;
  bit         busy_hist [int];
  bit         txv_hist  [int];

  int         rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int         mx_gid [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  logic [7:0] mx_dat [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h20, 8'h21, 8'hA4, 8'hA5};

  int t0;
  int lows;
  int bad;
  int plen;
  int pick;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int og(input int j);
    return (j < obs_gid.size()) ? obs_gid[j] : -1;
  endfunction

  function automatic int od(input int j);
    return (j < obs_data.size()) ? int'(obs_data[j]) : -1;
  endfunction

  function automatic int oc(input int j);
    return (j < obs_cyc.size()) ? obs_cyc[j] : -1;
  endfunction

  function automatic int dc(input int j);
    return (j < done_cyc.size()) ? done_cyc[j] : -1;
  endfunction

  task automatic clear_obs();
    obs_gid.delete();
    obs_cyc.delete();
    obs_data.delete();
    done_cyc.delete();
    other_rdy = 1'b0;
  endtask

  // Reference model, advanced on every rising edge from the inputs that edge samples.
  always @(posedge clk) begin
    int c;
    cyc++;
    if (rst) begin
      m_owner = -1; m_sent = 0; m_gap = 0; m_ptr = 0; m_gid = 0;
      m_busy  = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_owner >= 0) begin
        if (bus.req_valid[m_owner] && bus.tx_ready) begin
          m_sent++;
          if (bus.req_last[m_owner] || m_sent == MB) begin
            m_ptr   = (m_owner + 1) % NR;
            m_done  = 1'b1;
            m_owner = -1;
            m_gap   = GC;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (bus.req_valid[c]) begin
            m_owner = c;
            m_gid   = c;
            m_sent  = 0;
            break;
          end
        end
      end
      m_busy = (m_owner >= 0) || (m_gap > 0);
    end
  end

  // Compare process: outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    logic          exp_v;
    logic [7:0]    exp_d;
    logic [NR-1:0] exp_r;
    exp_v = 1'b0;
    exp_d = '0;
    exp_r = '0;
    if (m_owner >= 0) begin
      exp_v = bus.req_valid[m_owner];
      exp_d = bus.req_data[8*m_owner +: 8];
      if (bus.tx_ready) exp_r[m_owner] = 1'b1;
    end
    checkOutput("tx_valid",  32'(bus.tx_valid),  32'(exp_v));
    checkOutput("tx_data",   32'(bus.tx_data),   32'(exp_d));
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_r));
    checkOutput("busy",      32'(busy),          32'(m_busy));
    checkOutput("grant_id",  32'(grant_id),      32'(m_gid));
    checkOutput("msg_done",  32'(msg_done),      32'(m_done));
    hs_mask        = bus.req_valid & bus.req_ready;
    busy_hist[cyc] = busy;
    txv_hist[cyc]  = bus.tx_valid;
    if ((bus.req_ready & ~4'b0010) != '0) other_rdy = 1'b1;
    if (bus.tx_valid && bus.tx_ready) begin
      obs_gid.push_back(int'(grant_id));
      obs_cyc.push_back(cyc);
      obs_data.push_back(bus.tx_data);
    end
    if (msg_done) done_cyc.push_back(cyc);
  end

  // One clock of stimulus: retire bytes accepted last cycle, then drive the next ones.
  task automatic applyStimulus(input bit do_rst);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    rst = do_rst;
    case (tx_mode)
      0:       bus.tx_ready = 1'b1;
      1: begin
        bus.tx_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
        bp_idx++;
      end
      default: bus.tx_ready = ($urandom_range(0, 9) < 7);
    endcase
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = src_q[i][0][7:0];
        bus.req_last[i]         = src_q[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'($urandom);
        bus.req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && m_owner < 0 && m_gap == 0)) begin
      applyStimulus(1'b0);
      n++;
    end
    checkOutput("drain_done", 32'(all_empty() && m_owner < 0 && m_gap == 0), 32'd1);
    repeat (2) applyStimulus(1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    rst           = 1'b1;
    bus.tx_ready  = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    repeat (2) applyStimulus(1'b1);
    applyStimulus(1'b0);
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_busy",      32'(busy),          32'd0);
    checkOutput("reset_tx_valid",  32'(bus.tx_valid),  32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_grant_id",  32'(grant_id),      32'd0);
    checkOutput("reset_msg_done",  32'(msg_done),      32'd0);

    $display("[TB] single requester message");
    clear_obs();
    src_q[2].push_back({1'b0, 8'h41});
    src_q[2].push_back({1'b0, 8'h42});
    src_q[2].push_back({1'b1, 8'h43});
    applyStimulus(1'b0);
    t0 = cyc;
    drain(200);
    checkOutput("single_count", 32'(obs_data.size()), 32'd3);
    checkOutput("single_b0",    32'(od(0)), 32'h41);
    checkOutput("single_b1",    32'(od(1)), 32'h42);
    checkOutput("single_b2",    32'(od(2)), 32'h43);
    checkOutput("single_gid",   32'(og(0) + og(1) + og(2)), 32'd6);
    checkOutput("single_c0",    32'(oc(0)), 32'(t0 + 1));
    checkOutput("single_c2",    32'(oc(2)), 32'(t0 + 3));
    checkOutput("single_done",  32'(done_cyc.size()), 32'd1);
    checkOutput("model_ptr_single", 32'(m_ptr), 32'd3);

    $display("[TB] pointer after single message");
    clear_obs();
    src_q[0].push_back({1'b1, 8'h60});
    src_q[3].push_back({1'b1, 8'h63});
    drain(200);
    checkOutput("ptr_first_gid",  32'(og(0)), 32'd3);
    checkOutput("ptr_second_gid", 32'(og(1)), 32'd0);

    $display("[TB] round robin after reset");
    applyStimulus(1'b1);
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) src_q[i].push_back({1'b1, 8'(i*16 + k)});
    end
    drain(400);
    checkOutput("rr_count", 32'(obs_gid.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("rr_gid%0d", j),  32'(og(j)), 32'(rr_exp[j]));
      checkOutput($sformatf("rr_data%0d", j), 32'(od(j)), 32'(rr_exp[j]*16 + j/4));
    end
    checkOutput("rr_done", 32'(done_cyc.size()), 32'd8);

    $display("[TB] backpressure");
    clear_obs();
    tx_mode = 1;
    bp_idx  = 0;
    for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3), 8'(8'h10 + b)});
    drain(200);
    tx_mode = 0;
    checkOutput("bp_count", 32'(obs_data.size()), 32'd4);
    for (int j = 0; j < 4; j++) checkOutput($sformatf("bp_b%0d", j), 32'(od(j)), 32'(8'h10 + j));
    checkOutput("bp_other_ready", 32'(other_rdy), 32'd0);

    $display("[TB] forced release at byte limit");
    clear_obs();
    for (int b = 0; b < 6; b++) src_q[0].push_back({(b == 5), 8'(8'hA0 + b)});
    src_q[1].push_back({1'b0, 8'h20});
    src_q[1].push_back({1'b1, 8'h21});
    drain(400);
    checkOutput("max_count", 32'(obs_data.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("max_gid%0d", j),  32'(og(j)), 32'(mx_gid[j]));
      checkOutput($sformatf("max_data%0d", j), 32'(od(j)), 32'(mx_dat[j]));
    end
    checkOutput("max_done", 32'(done_cyc.size()), 32'd3);

    $display("[TB] idle gap between messages");
    clear_obs();
    src_q[3].push_back({1'b1, 8'h70});
    src_q[3].push_back({1'b1, 8'h71});
    drain(200);
    t0   = oc(0);
    lows = 0;
    for (int c = 0; c < 4; c++) if (!busy_hist[t0 + c]) lows++;
    checkOutput("gap_second_xfer", 32'(oc(1)), 32'(t0 + 5));
    checkOutput("gap_txv_before",  32'(txv_hist[t0 + 4]), 32'd0);
    checkOutput("gap_busy_lows",   32'(lows), 32'd0);
    checkOutput("gap_done_cycle",  32'(dc(0)), 32'(t0 + 1));

    $display("[TB] reset in the middle of a message");
    clear_obs();
    for (int b = 0; b < 4; b++) src_q[0].push_back({(b == 3), 8'(8'h50 + b)});
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("rstmid_first_byte", 32'(od(0)), 32'h50);
    checkOutput("rstmid_tx_valid",   32'(bus.tx_valid), 32'd0);
    checkOutput("rstmid_busy",       32'(busy), 32'd0);
    checkOutput("rstmid_grant_id",   32'(grant_id), 32'd0);
    checkOutput("model_ptr_rstmid",  32'(m_ptr), 32'd0);
    clear_obs();
    src_q[3].push_back({1'b0, 8'h30});
    src_q[3].push_back({1'b1, 8'h31});
    drain(200);
    checkOutput("rstmid_after_count", 32'(obs_data.size()), 32'd2);
    checkOutput("rstmid_after_gid",   32'(og(0)), 32'd3);
    checkOutput("rstmid_after_b0",    32'(od(0)), 32'h30);
    checkOutput("rstmid_after_b1",    32'(od(1)), 32'h31);

    $display("[TB] randomized traffic");
    clear_obs();
    for (int i = 0; i < NR; i++) exp_stream[i].delete();
    tx_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        pick = $urandom_range(0, NR - 1);
        if (src_q[pick].size() < 12) begin
          plen = $urandom_range(1, 6);
          for (int b = 0; b < plen; b++) begin
            logic [7:0] v;
            v = 8'($urandom);
            src_q[pick].push_back({(b == plen - 1), v});
            exp_stream[pick].push_back(v);
          end
        end
      end
      for (int i = 0; i < NR; i++) hold[i] = ($urandom_range(0, 9) == 0);
      applyStimulus(1'b0);
    end
    hold    = '0;
    tx_mode = 0;
    drain(3000);
    for (int i = 0; i < NR; i++) begin
      int got_n;
      got_n = 0;
      bad   = 0;
      for (int j = 0; j < obs_gid.size(); j++) begin
        if (obs_gid[j] == i) begin
          if (got_n >= exp_stream[i].size() || obs_data[j] != exp_stream[i][got_n]) bad++;
          got_n++;
        end
      end
      checkOutput($sformatf("stream%0d_len", i), 32'(got_n), 32'(exp_stream[i].size()));
      checkOutput($sformatf("stream%0d_bad", i), 32'(bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter between NUM_REQ independent byte sources using round-robin arbitration.
- A grant is held for a whole message: until the source marks its last byte, or until MAX_BYTES bytes have been sent.
- Sits between the requester logic (command/response formatters, debug printers) and the uart_tx tx_valid/tx_ready/tx_data interface.
- Optionally inserts a programmable idle gap between messages so a receiver can resynchronise.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_BYTES, 64, maximum bytes per grant before forced release; legal range 1..255.
- GAP_CYCLES, 0, clk cycles of enforced idle between the end of one grant and the next arbitration; 0 means no gap.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8*i+7:8*i].
- req_last  input  NUM_REQ  qualifies req_data[i] as the final byte of a message.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- tx_valid  output  1  byte valid toward uart_tx.
- tx_data  output  8  byte toward uart_tx.
- tx_ready  input  1  uart_tx is able to take a byte.
- busy  output  1  high while in GRANT or GAP.
- grant_id  output  clog2(NUM_REQ)  index of the current/last granted requester.
- msg_done  output  1  one-cycle pulse on the cycle after a grant is released.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and overrides all other activity.
- Reset values:
  - State = IDLE; rr_ptr = 0; grant_id = 0; byte_cnt = 0; gap_cnt = 0.
  - Registered outputs: busy = 0, msg_done = 0.
  - Combinational outputs: tx_valid = 0 and req_ready = 0 while in IDLE, so they are also 0 out of reset.
- Transfer rule:
  - Downstream: a byte moves when tx_valid && tx_ready.
  - Upstream: requester i's byte is consumed when req_valid[i] && req_ready[i].
  - These two events are the same event.
- Combinational datapath while in GRANT:
  - tx_valid = req_valid[grant_id].
  - tx_data = req_data[grant_id].
  - req_ready[i] = (i == grant_id) && tx_ready.
- Outside GRANT: tx_valid = 0, req_ready = 0, tx_data = 0.
- tx_valid must never depend combinationally on tx_ready.
- IDLE state:
  - If any req_valid bit is set, select the first set bit at or above rr_ptr, searching upward with wrap modulo NUM_REQ.
  - Register the winner into grant_id, clear byte_cnt, go to GRANT.
  - Latency: req_valid sampled at edge N gives tx_valid high in the cycle after edge N.
- GRANT state:
  - On each transfer, byte_cnt increments.
  - Release occurs when a transfer has req_last[grant_id] = 1, or when byte_cnt+1 == MAX_BYTES.
  - On release: rr_ptr = (grant_id+1) mod NUM_REQ; msg_done pulses next cycle; next state is GAP if GAP_CYCLES > 0, else IDLE.
  - If req_last and the MAX_BYTES limit hit on the same transfer, there is a single release and a single msg_done.
  - Forced release does not drop bytes; the requester resumes its message on its next grant.
- Stalls and held grants:
  - The granted requester deasserting req_valid stalls the link; the grant is held and no timeout applies.
  - Requests from other requesters are ignored until release.
- GAP state:
  - gap_cnt counts up from 0; at GAP_CYCLES-1 go to IDLE.
  - The next grant's tx_valid therefore appears no earlier than GAP_CYCLES+2 cycles after the final transfer.
- Fairness: rr_ptr only changes on release, so a requester that is continuously valid waits at most NUM_REQ-1 grants.
- Counter widths: byte_cnt is 8 bits; gap_cnt is clog2(GAP_CYCLES+1) bits, minimum 1. Neither counter wraps, because the transitions reset them.
- Reset mid-message: rst in GRANT or GAP returns to IDLE on that edge. Downstream sees tx_valid drop and the partial message is abandoned; recovery is the requesters' responsibility.
- busy: registered, equal to (next_state != IDLE).
- grant_id: holds its last value in IDLE and GAP.

Test Plan:
- Single requester: req 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready always 1.
  - tx_data sequence is 0x41,0x42,0x43 on 3 consecutive cycles; first one cycle after req_valid.
  - grant_id = 2; msg_done pulses once; rr_ptr = 3.
- Round robin: all 4 requesters continuously valid, each sending 1-byte messages with last = 1.
  - Grant order 0,1,2,3,0,1; each grant lasts exactly one transfer.
- Backpressure: tx_ready toggles 1,0,0,1 while req 1 streams 0x10..0x13.
  - No byte is duplicated or lost; req_ready[1] mirrors tx_ready; no other req_ready bit rises.
- MAX_BYTES = 4: req 0 sends 6 bytes with last on byte 6, while req 1 is valid.
  - Bytes 1-4 come from req 0, then req 1's message, then bytes 5-6 from req 0.
- GAP_CYCLES = 3: two back-to-back 1-byte messages.
  - busy stays high across the gap; the second tx_valid rises exactly 5 cycles after the first transfer.
- Reset mid-message: rst asserted on the 2nd byte of a 4-byte message.
  - Next cycle tx_valid = 0, busy = 0, grant_id = 0, rr_ptr = 0.
  - After release, req 3 valid alone is granted normally.
